// File: rtl/rom_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// rom_arbiter_pkg : shared FSM encoding, requester IDs and ROM memory map
// Revision 1.0
// ============================================================================
package rom_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    localparam logic REQ_P = 1'b0;
    localparam logic REQ_S = 1'b1;

    localparam logic [23:0] MAIN_ROM_END = 24'h07FFFF;
    localparam logic [23:0] SND_ROM_END  = 24'h01FFFF;
    localparam logic [23:0] SND_BASE_DEF = 24'h080000;

endpackage
`default_nettype wire

// File: rtl/rom_port_ctl.sv
`default_nettype none
// ============================================================================
// rom_port_ctl : per-CPU done flag, DTACK, read-data register and abort tracking
// Revision 1.0
// ============================================================================
module rom_port_ctl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rom_cs,
    input  logic        as_n,
    input  logic        grant,
    input  logic        ack,
    input  logic [15:0] rom_data,
    output logic        pend,
    output logic [15:0] dout,
    output logic        dtack_n
);

    logic        done_q, done_d;
    logic        inflight_q, inflight_d;
    logic        abort_q, abort_d;
    logic        dtack_n_q, dtack_n_d;
    logic [15:0] dout_q, dout_d;

    assign pend    = rom_cs & ~as_n & ~done_q & ~inflight_q;
    assign dout    = dout_q;
    assign dtack_n = dtack_n_q;

    always_comb begin
        done_d     = done_q;
        inflight_d = inflight_q;
        abort_d    = abort_q;
        dtack_n_d  = dtack_n_q;
        dout_d     = dout_q;

        if (as_n) begin
            dtack_n_d = 1'b1;
            done_d    = 1'b0;
        end
        // A strobe that ends while the read is outstanding poisons the result
        if (inflight_q && as_n) begin
            abort_d = 1'b1;
        end
        if (grant) begin
            inflight_d = 1'b1;
            abort_d    = 1'b0;
        end
        if (ack) begin
            inflight_d = 1'b0;
            abort_d    = 1'b0;
            if (!abort_q && !as_n) begin
                dout_d    = rom_data;
                dtack_n_d = 1'b0;
                done_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
            abort_q    <= 1'b0;
            dtack_n_q  <= 1'b1;
            dout_q     <= 16'h0000;
        end else begin
            done_q     <= done_d;
            inflight_q <= inflight_d;
            abort_q    <= abort_d;
            dtack_n_q  <= dtack_n_d;
            dout_q     <= dout_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
// rom_arbiter : alternating share of one SDRAM ROM read port between two 68000s
// Revision 1.0
// ============================================================================
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter logic [23:0] SND_BASE = SND_BASE_DEF,
    parameter int          ADDR_W   = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              p_rom_cs,
    input  logic              p_as_n,
    input  logic [ADDR_W-1:0] p_a,
    output logic [15:0]       p_dout,
    output logic              p_dtack_n,
    input  logic              s_rom_cs,
    input  logic              s_as_n,
    input  logic [ADDR_W-1:0] s_a,
    output logic [15:0]       s_dout,
    output logic              s_dtack_n,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [15:0]       rom_data
);

    logic              p_cs_q, p_as_n_q, s_cs_q, s_as_n_q;
    logic [ADDR_W-1:1] p_a_q, s_a_q;
    logic              unused_addr_lsb;

    arb_state_t        state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              rom_req_q, rom_req_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

    logic              p_pend, s_pend, p_grant, s_grant, p_ack, s_ack;
    logic [ADDR_W-1:1] snd_word_addr;

    assign unused_addr_lsb = p_a[0] ^ s_a[0];

    // Pending decisions use registered copies of the asynchronous CPU bus
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_cs_q   <= 1'b0;
            p_as_n_q <= 1'b1;
            p_a_q    <= '0;
            s_cs_q   <= 1'b0;
            s_as_n_q <= 1'b1;
            s_a_q    <= '0;
        end else begin
            p_cs_q   <= p_rom_cs;
            p_as_n_q <= p_as_n;
            p_a_q    <= p_a[ADDR_W-1:1];
            s_cs_q   <= s_rom_cs;
            s_as_n_q <= s_as_n;
            s_a_q    <= s_a[ADDR_W-1:1];
        end
    end

    assign snd_word_addr = s_a_q + SND_BASE[ADDR_W-1:1];

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        rom_req_d  = rom_req_q;
        rom_addr_d = rom_addr_q;
        p_grant    = 1'b0;
        s_grant    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (p_pend && (!s_pend || last_q == REQ_S)) begin
                    p_grant    = 1'b1;
                    owner_d    = REQ_P;
                    last_d     = REQ_P;
                    rom_req_d  = 1'b1;
                    rom_addr_d = {p_a_q, 1'b0};
                    state_d    = ST_BUSY;
                end else if (s_pend) begin
                    s_grant    = 1'b1;
                    owner_d    = REQ_S;
                    last_d     = REQ_S;
                    rom_req_d  = 1'b1;
                    rom_addr_d = {snd_word_addr, 1'b0};
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (rom_ack) begin
                    rom_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Acks outside BUSY are stray and must not reach either port
    assign p_ack = (state_q == ST_BUSY) && rom_ack && (owner_q == REQ_P);
    assign s_ack = (state_q == ST_BUSY) && rom_ack && (owner_q == REQ_S);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            last_q     <= REQ_S;
            owner_q    <= REQ_P;
            rom_req_q  <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            rom_req_q  <= rom_req_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    assign rom_req  = rom_req_q;
    assign rom_addr = rom_addr_q;

    rom_port_ctl u_port_p (
        .clk      (clk),
        .reset_n  (reset_n),
        .rom_cs   (p_cs_q),
        .as_n     (p_as_n_q),
        .grant    (p_grant),
        .ack      (p_ack),
        .rom_data (rom_data),
        .pend     (p_pend),
        .dout     (p_dout),
        .dtack_n  (p_dtack_n)
    );

    rom_port_ctl u_port_s (
        .clk      (clk),
        .reset_n  (reset_n),
        .rom_cs   (s_cs_q),
        .as_n     (s_as_n_q),
        .grant    (s_grant),
        .ack      (s_ack),
        .rom_data (rom_data),
        .pend     (s_pend),
        .dout     (s_dout),
        .dtack_n  (s_dtack_n)
    );

endmodule
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rom_arbiter : directed self-checking bench for rom_arbiter
// Revision 1.0
// ============================================================================
module tb_rom_arbiter;

    logic        clk;
    logic        reset_n;
    logic        p_rom_cs, p_as_n, s_rom_cs, s_as_n;
    logic [23:0] p_a, s_a;
    logic [15:0] p_dout, s_dout;
    logic        p_dtack_n, s_dtack_n;
    logic        rom_req;
    logic [23:0] rom_addr;
    logic        rom_ack;
    logic [15:0] rom_data;

    int          n_checks;
    int          n_errors;
    logic [15:0] exp_s_dout;

    rom_arbiter u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .p_rom_cs  (p_rom_cs),
        .p_as_n    (p_as_n),
        .p_a       (p_a),
        .p_dout    (p_dout),
        .p_dtack_n (p_dtack_n),
        .s_rom_cs  (s_rom_cs),
        .s_as_n    (s_as_n),
        .s_a       (s_a),
        .s_dout    (s_dout),
        .s_dtack_n (s_dtack_n),
        .rom_req   (rom_req),
        .rom_addr  (rom_addr),
        .rom_ack   (rom_ack),
        .rom_data  (rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse(input logic [15:0] d);
        rom_ack  = 1'b1;
        rom_data = d;
        tick();
        rom_ack  = 1'b0;
        rom_data = 16'h0000;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset_n    = 1'b0;
        p_rom_cs   = 1'b0;
        p_as_n     = 1'b1;
        p_a        = 24'h0;
        s_rom_cs   = 1'b0;
        s_as_n     = 1'b1;
        s_a        = 24'h0;
        rom_ack    = 1'b0;
        rom_data   = 16'h0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        check("rst_p_dtack", 32'(p_dtack_n), 32'h1);
        check("rst_s_dtack", 32'(s_dtack_n), 32'h1);
        check("rst_req", 32'(rom_req), 32'h0);
        check("rst_addr", 32'(rom_addr), 32'h0);
        check("rst_p_dout", 32'(p_dout), 32'h0);
        check("rst_s_dout", 32'(s_dout), 32'h0);

        // Main only: inputs registered, then one cycle to rom_req
        p_rom_cs = 1'b1; p_a = 24'h001234; p_as_n = 1'b0;
        tick();
        check("p_req_lat1", 32'(rom_req), 32'h0);
        tick();
        check("p_req", 32'(rom_req), 32'h1);
        check("p_addr", 32'(rom_addr), 32'h001234);
        tick(); tick();
        check("p_req_hold", 32'(rom_req), 32'h1);
        check("p_dtack_wait", 32'(p_dtack_n), 32'h1);
        ack_pulse(16'hBEEF);
        check("p_dout", 32'(p_dout), 32'hBEEF);
        check("p_dtack", 32'(p_dtack_n), 32'h0);
        check("p_req_drop", 32'(rom_req), 32'h0);
        tick();
        check("p_no_reissue", 32'(rom_req), 32'h0);
        p_as_n = 1'b1; p_rom_cs = 1'b0;
        tick();
        check("p_dtack_rel1", 32'(p_dtack_n), 32'h0);
        tick();
        check("p_dtack_rel", 32'(p_dtack_n), 32'h1);
        check("p_dout_hold", 32'(p_dout), 32'hBEEF);

        // Sound offset
        s_rom_cs = 1'b1; s_a = 24'h00FFFE; s_as_n = 1'b0;
        tick(); tick();
        check("s_req", 32'(rom_req), 32'h1);
        check("s_addr", 32'(rom_addr), 32'h08FFFE);
        tick();
        ack_pulse(16'h5A5A);
        check("s_dout", 32'(s_dout), 32'h5A5A);
        check("s_dtack", 32'(s_dtack_n), 32'h0);
        check("s_p_dtack", 32'(p_dtack_n), 32'h1);
        s_as_n = 1'b1; s_rom_cs = 1'b0;
        tick(); tick();
        check("s_dtack_rel", 32'(s_dtack_n), 32'h1);

        // Simultaneous strobes after reset: order P, S, P, S
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        for (int r = 0; r < 2; r++) begin
            p_rom_cs = 1'b1; p_a = 24'h000200; p_as_n = 1'b0;
            s_rom_cs = 1'b1; s_a = 24'h000010; s_as_n = 1'b0;
            tick(); tick();
            check("alt_first_req", 32'(rom_req), 32'h1);
            check("alt_first_p", 32'(rom_addr), 32'h000200);
            ack_pulse(16'h1001 + 16'(r));
            check("alt_p_dout", 32'(p_dout), 32'h1001 + 32'(r));
            check("alt_p_dtack", 32'(p_dtack_n), 32'h0);
            tick();
            check("alt_second_req", 32'(rom_req), 32'h1);
            check("alt_second_s", 32'(rom_addr), 32'h080010);
            ack_pulse(16'h2002 + 16'(r));
            check("alt_s_dout", 32'(s_dout), 32'h2002 + 32'(r));
            check("alt_s_dtack", 32'(s_dtack_n), 32'h0);
            p_as_n = 1'b1; s_as_n = 1'b1;
            tick(); tick();
        end
        exp_s_dout = 16'h2003;

        // Abort: sound in flight, strobe drops, main waiting
        s_a = 24'h000020; s_as_n = 1'b0;
        tick(); tick();
        check("ab_s_addr", 32'(rom_addr), 32'h080020);
        p_a = 24'h000300; p_as_n = 1'b0;
        s_as_n = 1'b1;
        tick(); tick(); tick();
        check("ab_still_busy", 32'(rom_req), 32'h1);
        ack_pulse(16'h1111);
        check("ab_s_dtack", 32'(s_dtack_n), 32'h1);
        check("ab_s_dout", 32'(s_dout), 32'(exp_s_dout));
        tick();
        check("ab_p_req", 32'(rom_req), 32'h1);
        check("ab_p_addr", 32'(rom_addr), 32'h000300);
        ack_pulse(16'h3333);
        check("ab_p_dout", 32'(p_dout), 32'h3333);
        check("ab_s_dout2", 32'(s_dout), 32'(exp_s_dout));
        p_as_n = 1'b1;
        tick(); tick();

        // Reset mid-BUSY with sound DTACK still asserted
        s_a = 24'h000040; s_as_n = 1'b0;
        tick(); tick();
        ack_pulse(16'h4444);
        check("rb_s_dtack_pre", 32'(s_dtack_n), 32'h0);
        p_a = 24'h000400; p_as_n = 1'b0;
        tick(); tick();
        check("rb_busy", 32'(rom_req), 32'h1);
        #3;
        reset_n = 1'b0;
        #1;
        check("rb_req", 32'(rom_req), 32'h0);
        check("rb_p_dtack", 32'(p_dtack_n), 32'h1);
        check("rb_s_dtack", 32'(s_dtack_n), 32'h1);
        check("rb_p_dout", 32'(p_dout), 32'h0);
        p_as_n = 1'b1; s_as_n = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        ack_pulse(16'hDEAD);
        tick();
        check("late_ack_req", 32'(rom_req), 32'h0);
        check("late_ack_p_dout", 32'(p_dout), 32'h0);
        check("late_ack_s_dout", 32'(s_dout), 32'h0);
        check("late_ack_p_dtack", 32'(p_dtack_n), 32'h1);
        check("late_ack_s_dtack", 32'(s_dtack_n), 32'h1);

        // Odd byte address rounds down to the word
        p_a = 24'h000101; p_as_n = 1'b0;
        tick(); tick();
        check("odd_addr", 32'(rom_addr), 32'h000100);
        ack_pulse(16'h7777);
        check("odd_dout", 32'(p_dout), 32'h7777);
        p_as_n = 1'b1; p_rom_cs = 1'b0; s_rom_cs = 1'b0;
        tick(); tick();

        // Non-ROM cycle: no request
        p_as_n = 1'b0;
        tick(); tick(); tick();
        check("nonrom_req", 32'(rom_req), 32'h0);
        check("nonrom_dtack", 32'(p_dtack_n), 32'h1);
        p_as_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single SDRAM ROM read port between the main 68000 program ROM (0x000000–0x07FFFF) and the sound 68000 program ROM (0x000000–0x01FFFF).
- Sits between the chip-select decoder and the SDRAM controller. Takes each CPU's rom chip select, address strobe and address.
- Issues one outstanding SDRAM read at a time, with fair alternation between the two CPUs.
- Returns the read data to each CPU and holds that CPU's DTACK until its bus cycle ends.

Parameters:
- SND_BASE, 24'h080000, byte offset added to the sound CPU address to form the SDRAM address; the sound ROM region follows the main ROM.
- ADDR_W, 24, SDRAM byte address width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- p_rom_cs  in  1  main CPU ROM select (from chip select decoder)
- p_as_n  in  1  main CPU address strobe, active low
- p_a  in  24  main CPU byte address
- p_dout  out  16  ROM word returned to main CPU
- p_dtack_n  out  1  main CPU data acknowledge, active low
- s_rom_cs  in  1  sound CPU ROM select
- s_as_n  in  1  sound CPU address strobe, active low
- s_a  in  24  sound CPU byte address
- s_dout  out  16  ROM word returned to sound CPU
- s_dtack_n  out  1  sound CPU data acknowledge, active low
- rom_req  out  1  read request to SDRAM; held high until acknowledged
- rom_addr  out  ADDR_W  SDRAM byte address, bit 0 forced 0
- rom_ack  in  1  one-cycle pulse: rom_data valid this cycle
- rom_data  in  16  SDRAM read word

Behaviour:
- Reset (async, reset_n low):
  - p_dtack_n = s_dtack_n = 1
  - rom_req = 0, rom_addr = 0, p_dout = s_dout = 0
  - state = IDLE, last_grant = SND (main CPU wins first contention), both done flags = 0
- Pending condition: X_pend = X_rom_cs & !X_as_n & !X_done & !X_inflight. It is evaluated every clk from registered inputs.
- FSM states: IDLE and BUSY.
- IDLE:
  - Only p_pend: grant P. rom_addr <= {p_a[23:1],0}.
  - Only s_pend: grant S. rom_addr <= {s_a[23:1]+SND_BASE[23:1],0}, with 24-bit wrap.
  - Both pending: grant the requester not equal to last_grant.
  - On any grant: rom_req <= 1, last_grant <= granted, state <= BUSY. Latency is 1 cycle from the pending condition to rom_req high.
- BUSY:
  - rom_req stays 1 and rom_addr stays stable until rom_ack.
  - On rom_ack: rom_req <= 0, X_dout <= rom_data, X_dtack_n <= 0, X_done <= 1, state <= IDLE.
  - A new grant is allowed in the cycle after ack; there is no back-to-back grant in the ack cycle.
- DTACK release:
  - When X_as_n is sampled high: X_dtack_n <= 1 and X_done <= 0 in the next cycle.
  - X_dout holds its value.
- Strobe abort while in flight (X_as_n rises before ack):
  - The request completes normally; the SDRAM is never abandoned.
  - On ack, data is discarded, X_dtack_n stays 1 and X_done stays 0.
- Non-ROM cycles (X_rom_cs = 0): no request is made and X_dtack_n is untouched. Other DTACK sources are ORed externally.
- rom_ack while IDLE (spurious, or after a reset mid-operation): ignored, no output change.
- Reset mid-BUSY: everything returns to reset values immediately. Any late ack is ignored per the rule above.
- Back-to-back same requester: a new cycle needs as_n high then low again, because done blocks re-issue within one strobe.

Decomposition:
- Shared package: FSM state encoding (IDLE, BUSY) and requester ID constants (REQ_P = 0, REQ_S = 1).
- Memory-map constants also go in the package: main ROM end 24'h07FFFF, sound ROM end 24'h01FFFF, SND_BASE.
- One natural sub-module: rom_port_ctl, instantiated twice. It owns each CPU's done flag, DTACK, dout register and abort-tracking logic. The top module holds the FSM and the alternation.

Test Plan:
- Main only: p_rom_cs = 1, p_as_n 1→0, p_a = 24'h001234. Expect rom_req high next cycle with rom_addr = 24'h001234. Ack 3 cycles later with rom_data = 16'hBEEF. Expect p_dout = 16'hBEEF and p_dtack_n = 0 next cycle; p_dtack_n = 1 one cycle after p_as_n rises.
- Sound offset: s_a = 24'h00FFFE. Expect rom_addr = 24'h08FFFE; s_dout gets the returned data and p_dtack_n stays 1.
- Simultaneous strobes after reset: expect main granted first, then sound granted in the cycle after the main ack. Repeat and check the grant order alternates P, S, P, S.
- Abort: sound strobe rises while BUSY. Ack arrives with 16'h1111: expect s_dtack_n to stay 1 and s_dout to be unchanged. A pending main request is granted the next cycle.
- Reset mid-BUSY: assert reset_n low asynchronously. Expect rom_req = 0 and both dtack_n = 1 immediately. A late rom_ack after release causes no output change.
- Odd address: p_a = 24'h000101. Expect rom_addr = 24'h000100.
